// File: rtl/frodo_mac_pkg.sv
// Shared widths, FSM state encodings and the LOGQ mask helper for the
// Frodo MAC sequencer.
package frodo_mac_pkg;

  localparam int ELEM_W       = 8;
  localparam int COEF_W       = 16;
  localparam int LOGQ_DEFAULT = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_OUT   = 3'd4;

  // All-ones in the low logq bits; logq=16 yields 16'hFFFF without overflow.
  function automatic logic [COEF_W-1:0] logqMask(input int logq);
    logic [COEF_W:0] w_full;
    w_full = (COEF_W+1)'(1) << logq;
    return w_full[COEF_W-1:0] - COEF_W'(1);
  endfunction

endpackage

// File: rtl/pe_mac_sequencer.sv
// Initiator for the MAC PE protocol: streams (a,b) pairs into one PE and
// returns bias + sum(a*b) mod 2^LOGQ on a valid/ready output.
module pe_mac_sequencer
  import frodo_mac_pkg::*;
#(
  parameter int LEN_W   = 11,
  parameter int LOGQ    = LOGQ_DEFAULT,
  parameter int TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [COEF_W-1:0] bias,
  output logic              busy,
  output logic              err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ELEM_W-1:0] in_a,
  input  logic [COEF_W-1:0] in_b,
  output logic              pe_en,
  output logic [ELEM_W-1:0] pe_a,
  output logic [COEF_W-1:0] pe_b,
  output logic [COEF_W-1:0] pe_c,
  input  logic [COEF_W-1:0] pe_result,
  input  logic              pe_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [COEF_W-1:0] out_data
);

  localparam int                WD_W = $clog2(TIMEOUT) + 1;
  localparam logic [COEF_W-1:0] MASK = logqMask(LOGQ);

  logic [2:0]        r_state;
  logic [COEF_W-1:0] r_acc;
  logic [LEN_W-1:0]  r_cnt;
  logic [WD_W-1:0]   r_wd;
  logic              r_busy;
  logic              r_err;
  logic              r_peEn;
  logic [ELEM_W-1:0] r_peA;
  logic [COEF_W-1:0] r_peB;

  // pe_en is raised on the handshake edge so it is high exactly during ISSUE,
  // which also guarantees the PE has finished the previous element.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_wd    <= '0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_peEn  <= 1'b0;
      r_peA   <= '0;
      r_peB   <= '0;
    end else begin
      r_peEn <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_acc   <= bias & MASK;
            r_cnt   <= len;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= (len == '0) ? ST_OUT : ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (in_valid) begin
            r_peA   <= in_a;
            r_peB   <= in_b;
            r_peEn  <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_wd    <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (pe_done) begin
            r_acc   <= pe_result & MASK;
            r_cnt   <= r_cnt - LEN_W'(1);
            r_state <= (r_cnt == LEN_W'(1)) ? ST_OUT : ST_FETCH;
          end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
            // A silent PE abandons the row; err stays set until the next start.
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_wd <= r_wd + WD_W'(1);
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign err       = r_err;
  assign in_ready  = (r_state == ST_FETCH);
  assign pe_en     = r_peEn;
  assign pe_a      = r_peA;
  assign pe_b      = r_peB;
  assign pe_c      = r_acc;
  assign out_valid = (r_state == ST_OUT);
  assign out_data  = (r_state == ST_OUT) ? r_acc : '0;

endmodule
